// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice reused per nibble,
// LSB nibble first, carry registered between nibbles.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ov
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ov_q, ov_d;

    // Carry-lookahead slice on the low nibbles of the operand shift registers
    logic [3:0] sl_a, sl_b, sl_g, sl_p, sl_sum;
    logic [4:0] sl_c;
    logic       sl_cout, sl_ov;

    always_comb begin
        sl_a    = a_q[3:0];
        sl_b    = b_q[3:0];
        sl_g    = sl_a & sl_b;
        sl_p    = sl_a ^ sl_b;
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_sum  = sl_p ^ sl_c[3:0];
        sl_cout = sl_c[4];
        sl_ov   = sl_c[3] ^ sl_c[4];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = {sl_sum, sum_q[WIDTH-1:4]};
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = sl_cout;
                cnt_d   = cnt_q + CW'(1);
                // Only the top nibble's carry/overflow describe the full word
                if (cnt_q == LAST) begin
                    cout_d  = sl_cout;
                    ov_d    = sl_ov;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ov_q    <= ov_d;
        end
    end

    assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ov    = ov_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vector table, multi-cycle corner
// sequences, and random regression on 16- and 8-bit builds against a+b+cin.
module tb_nibble_serial_adder;

    localparam int NIB16 = 4;
    localparam int NIB8  = 2;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        ready, busy, done, cout, ov;
    logic [15:0] sum;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, busy8, done8, cout8, ov8;
    logic [7:0]  sum8;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ov(ov)
    );

    nibble_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ready(ready8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ov(ov8)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout, exp_ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at the first negedge after the accepting edge; returns at the done negedge.
    task automatic wait_done(input bit w8, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!(w8 ? done8 : done) && lat < TMO) begin
            if (w8 ? busy8 : busy) bc++;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic add16(input logic [15:0] ia, ib, input logic ic,
                         output logic [15:0] s, output logic co, o,
                         output int lat, output int bc);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat, bc);
        s = sum; co = cout; o = ov;
    endtask

    task automatic add8(input logic [7:0] ia, ib, input logic ic,
                        output logic [7:0] s, output logic co, o, output int lat);
        int bc;
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(1'b1, lat, bc);
        s = sum8; co = cout8; o = ov8;
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] s;
        logic        co, o;
        logic [16:0] full;
        logic [8:0]  full8;
        logic [7:0]  s8;
        logic [15:0] ra, rb;
        logic [7:0]  ra8, rb8;
        logic        rc;
        int          lat, bc, ndone;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        #1;
        chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);     chk("rst_cout", cout, 0); chk("rst_ov", ov, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            add16(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, o, lat, bc);
            chk($sformatf("vec%0d_lat", i), lat, NIB16);
            chk($sformatf("vec%0d_busy_cycles", i), bc, NIB16);
            chk($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
            chk($sformatf("vec%0d_cout", i), co, vecs[i].exp_cout);
            chk($sformatf("vec%0d_ov", i), o, vecs[i].exp_ov);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
            chk($sformatf("vec%0d_hold_sum", i), sum, vecs[i].exp_sum);
        end

        // start and operand changes while busy must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin ndone++; s = sum; end
            @(negedge clk);
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_sum", s, 16'h5556);

        // back-to-back: new start in the DONE cycle
        add16(16'h0001, 16'h0002, 1'b0, s, co, o, lat, bc);
        chk("b2b_first_sum", s, 16'h0003);
        chk("b2b_ready_in_done", ready, 1);
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_bubble", busy, 1);
        wait_done(1'b0, lat, bc);
        chk("b2b_lat", lat, NIB16);
        chk("b2b_sum", sum, 16'h1000);
        chk("b2b_cout", cout, 0);
        chk("b2b_ov", ov, 0);

        // reset in the middle of a run
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1); chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
        chk("midrst_sum", sum, 0);     chk("midrst_cout", cout, 0); chk("midrst_ov", ov, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst_no_done", ndone, 0);
        add16(16'h0001, 16'h0001, 1'b0, s, co, o, lat, bc);
        chk("midrst_next_sum", s, 16'h0002);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            add16(ra, rb, rc, s, co, o, lat, bc);
            chk("rnd16_lat", lat, NIB16);
            chk("rnd16_sum", s, full[15:0]);
            chk("rnd16_cout", co, full[16]);
            chk("rnd16_ov", o, (ra[15] == rb[15]) && (full[15] != ra[15]));
        end

        for (int i = 0; i < 300; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
            full8 = {1'b0, ra8} + {1'b0, rb8} + 9'(rc);
            add8(ra8, rb8, rc, s8, co, o, lat);
            chk("rnd8_lat", lat, NIB8);
            chk("rnd8_sum", s8, full8[7:0]);
            chk("rnd8_cout", co, full8[8]);
            chk("rnd8_ov", o, (ra8[7] == rb8[7]) && (full8[7] != ra8[7]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
